// File: rtl/rot_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : rot_cmd_queue
// Description : DEPTH-entry command FIFO feeding an external combinational
//               8-bit rotator, with a registered valid/ready result stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic [2:0]               in_amt,
    input  logic                     in_lr,
    output logic [7:0]               rot_data,
    output logic [2:0]               rot_amt,
    output logic                     rot_lr,
    input  logic [7:0]               rot_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [11:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_res_valid;
    logic [7:0]         r_res_data;

    logic               w_push;
    logic               w_pop;
    logic               w_res_free;
    logic               w_not_empty;
    logic [11:0]        w_head;

    // in_ready uses registered occupancy only, so a pop never opens it
    // combinationally in the same cycle.
    assign in_ready    = (r_count != c_FULL) && !flush;
    assign w_push      = in_valid && in_ready;
    assign w_not_empty = (r_count != '0);
    assign w_res_free  = !r_res_valid || res_ready;
    assign w_pop       = w_not_empty && w_res_free && !flush;

    assign w_head   = w_not_empty ? r_mem[r_rd_ptr] : 12'h000;
    assign rot_lr   = w_head[11];
    assign rot_amt  = w_head[10:8];
    assign rot_data = w_head[7:0];

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign count     = r_count;

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_lr, in_amt, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + {{(c_CNT_W-1){1'b0}}, w_push}
                               - {{(c_CNT_W-1){1'b0}}, w_pop};
        end
    end

    // Flush drops the valid flag but keeps the last result byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
        end else if (flush) begin
            r_res_valid <= 1'b0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_data  <= rot_out;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rot_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_cmd_queue
// Description : Self-checking bench for rot_cmd_queue with a queue-based
//               reference model, vector table and directed corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_lr;
    logic [7:0] rot_data;
    logic [2:0] rot_amt;
    logic       rot_lr;
    logic [7:0] rot_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [$clog2(DEPTH):0] count;

    int n_tests = 0;
    int n_fail  = 0;

    rot_cmd_queue #(.DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .rot_data  (rot_data),
        .rot_amt   (rot_amt),
        .rot_lr    (rot_lr),
        .rot_out   (rot_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external combinational rotator.
    function automatic logic [7:0] rotator(input logic [7:0] d, input logic [2:0] a, input logic lr);
        logic [15:0] dd;
        logic [15:0] s;
        dd = {d, d};
        if (lr) begin
            s = dd >> a;
            return s[7:0];
        end
        s = dd << a;
        return s[15:8];
    endfunction

    assign rot_out = rotator(rot_data, rot_amt, rot_lr);

    // Reference rotate, bit by bit: right moves bit0 toward bit7.
    function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a, input logic lr);
        logic [7:0] o;
        o = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (lr) o[j] = d[(j + int'(a)) % 8];
            else    o[(j + int'(a)) % 8] = d[j];
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected results of accepted, undelivered commands.
    logic [7:0] model_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            check("mon_count", 32'(count), 32'(model_q.size() - int'(res_valid)));
            check("mon_in_ready", 32'(in_ready),
                  32'(((model_q.size() - int'(res_valid)) != DEPTH) && !flush));
            if (flush) begin
                model_q.delete();
            end else begin
                if (res_valid && res_ready) begin
                    if (model_q.size() == 0) begin
                        check("mon_spurious_result", 32'(res_valid), 32'(0));
                    end else begin
                        check("mon_result", 32'(res_data), 32'(model_q.pop_front()));
                    end
                end
                if (in_valid && in_ready) begin
                    model_q.push_back(rot_ref(in_data, in_amt, in_lr));
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       lr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] cd [6];
    logic [2:0] ca [6];
    logic       cl [6];

    task automatic offer(input logic [7:0] d, input logic [2:0] a, input logic lr);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_lr    = lr;
    endtask

    initial begin
        vecs[0] = '{8'h81, 3'd1, 1'b1, 8'hC0};
        vecs[1] = '{8'h81, 3'd1, 1'b0, 8'h03};
        vecs[2] = '{8'hA5, 3'd4, 1'b1, 8'h5A};
        vecs[3] = '{8'h01, 3'd7, 1'b0, 8'h80};
        vecs[4] = '{8'h3C, 3'd0, 1'b1, 8'h3C};
        vecs[5] = '{8'hF0, 3'd3, 1'b0, 8'h87};
        vecs[6] = '{8'h96, 3'd7, 1'b1, 8'h2D};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        in_data = 8'h00; in_amt = 3'd0; in_lr = 1'b0;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_rot", 32'({rot_lr, rot_amt, rot_data}), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Single commands: two-edge latency, no bypass.
        for (int i = 0; i < 7; i++) begin
            offer(vecs[i].data, vecs[i].amt, vecs[i].lr);
            cyc();
            check("vec_count_after_accept", 32'(count), 1);
            check("vec_no_bypass", 32'(res_valid), 0);
            check("vec_head", 32'({rot_lr, rot_amt, rot_data}), 32'({vecs[i].lr, vecs[i].amt, vecs[i].data}));
            in_valid = 1'b0;
            cyc();
            check("vec_res_valid", 32'(res_valid), 1);
            check("vec_res_data", 32'(res_data), 32'(vecs[i].exp));
            check("vec_count_drained", 32'(count), 0);
            cyc();
            check("vec_res_consumed", 32'(res_valid), 0);
        end

        // Back-to-back: results on consecutive cycles.
        offer(8'h81, 3'd1, 1'b0); cyc();
        offer(8'hA5, 3'd4, 1'b1); cyc();
        check("b2b_res0", 32'({res_valid, res_data}), 32'({1'b1, 8'h03}));
        offer(8'h01, 3'd7, 1'b0); cyc();
        check("b2b_res1", 32'({res_valid, res_data}), 32'({1'b1, 8'h5A}));
        in_valid = 1'b0; cyc();
        check("b2b_res2", 32'({res_valid, res_data}), 32'({1'b1, 8'h80}));
        cyc();

        // Back-pressure: fill, stall, then pop with a push offered while full.
        for (int i = 0; i < 6; i++) begin
            cd[i] = 8'($urandom); ca[i] = 3'($urandom); cl[i] = 1'($urandom);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(cd[i], ca[i], cl[i]);
            cyc();
        end
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_res_data", 32'(res_data), 32'(rot_ref(cd[0], ca[0], cl[0])));
        offer(cd[5], ca[5], cl[5]);
        cyc();
        check("stall_count", 32'(count), 4);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_res_stable", 32'({res_valid, res_data}), 32'({1'b1, rot_ref(cd[0], ca[0], cl[0])}));
        res_ready = 1'b1;
        cyc();
        check("popfull_count", 32'(count), 3);
        check("popfull_in_ready", 32'(in_ready), 1);
        check("popfull_res", 32'(res_data), 32'(rot_ref(cd[1], ca[1], cl[1])));
        cyc();
        check("late_push_count", 32'(count), 3);
        check("late_push_res", 32'(res_data), 32'(rot_ref(cd[2], ca[2], cl[2])));
        in_valid = 1'b0;
        for (int i = 3; i < 6; i++) begin
            cyc();
            check("drain_res", 32'({res_valid, res_data}), 32'({1'b1, rot_ref(cd[i], ca[i], cl[i])}));
        end
        cyc();
        check("drain_idle", 32'({res_valid, count}), 0);

        // Flush with count=3 and a held result while a push is offered.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(cd[i], ca[i], cl[i]);
            cyc();
        end
        check("preflush_count", 32'(count), 3);
        check("preflush_res_valid", 32'(res_valid), 1);
        res_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_res_valid", 32'(res_valid), 0);
        check("flush_res_data_held", 32'(res_data), 32'(rot_ref(cd[0], ca[0], cl[0])));
        cyc();
        check("postflush_empty", 32'({res_valid, count}), 0);

        // Asynchronous reset mid-stream.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(cd[i], ca[i], cl[i]);
            cyc();
        end
        in_valid = 1'b0;
        check("prereset_count", 32'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("areset_count", 32'(count), 0);
        check("areset_res_valid", 32'(res_valid), 0);
        check("areset_res_data", 32'(res_data), 0);
        cyc();
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("postreset_idle", 32'({res_valid, count}), 0);
        end

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_lr     = 1'($urandom);
            res_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        begin
            int budget;
            budget = 0;
            while ((res_valid || count != 0) && budget < 20) begin
                cyc();
                budget++;
            end
            check("drain_timeout", 32'(budget < 20), 1);
        end
        cyc();
        check("final_empty", 32'(model_q.size()), 0);
        check("final_rot_zero", 32'({rot_lr, rot_amt, rot_data}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
